mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter for the 5-stage MIPS pipeline.
- Sits directly upstream of the register file and drives its write port (write address, write data, write enable).
- Captures MEM-stage results on the rising clock edge and performs load byte/halfword extraction and sign/zero extension.
- Selects among ALU result, loaded data and link address, and publishes a forwarding copy of the pending write for the ID/EX stages.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- AW, 5, register address width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all WB state; no new capture.
- flush  input  1  load a bubble into WB.
- m_valid  input  1  MEM stage holds a real instruction.
- m_regwr  input  1  instruction writes a GPR.
- m_rd  input  5  destination register.
- m_wbsel  input  2  writeback source: 00 = ALU, 01 = MEM, 10 = PC+8, 11 = reserved (treated as ALU).
- m_ldtype  input  3  load format: 000 = lw, 001 = lb, 010 = lbu, 011 = lh, 100 = lhu; others are treated as lw.
- m_alu  input  32  ALU result; bits [1:0] are the load byte offset.
- m_rdata  input  32  data-memory read word.
- m_pc  input  32  PC of the instruction.
- rf_a3  output  5  RF write address.
- rf_wd  output  32  RF write data.
- rf_wr  output  1  RF write enable.
- fwd_vld  output  1  equal to rf_wr; the forwarding path uses rf_a3/rf_wd.
- align_err  output  1  sticky misaligned-load flag.
- retire_cnt  output  32  count of retired valid instructions.

Behaviour:
- Reset (asynchronous, rst_n = 0): rf_a3 = 0, rf_wd = 0, rf_wr = 0, align_err = 0, retire_cnt = 0. Asserting reset mid-operation discards the instruction in WB immediately, with no write.
- Capture priority per posedge with rst_n = 1: flush > stall > normal.
  - flush: bubble; rf_wr = 0, rf_a3 = 0, rf_wd = 0; retire_cnt unchanged; align_err unchanged.
  - stall (without flush): all outputs and counters hold, so rf_wr stays asserted if it was. Repeated writes of the same value are harmless.
  - normal: capture the formatted result of the current m_* inputs.
- Latency: one cycle. Inputs sampled at posedge N appear on outputs after posedge N; the RF commits them at the following negedge.
- Write data formatting:
  - ALU / reserved source: rf_wd = m_alu.
  - PC+8 source: rf_wd = m_pc + 8, modulo 2^32 (0xFFFFFFFC + 8 = 0x00000004).
  - MEM source, little-endian, off = m_alu[1:0]:
    - lw: m_rdata.
    - lb / lbu: byte = m_rdata[8*off+7 : 8*off], sign- or zero-extended to 32 bits.
    - lh / lhu: half = m_rdata[16*off[1]+15 : 16*off[1]], sign- or zero-extended.
- Write enable: rf_wr = m_valid & m_regwr & (m_rd != 0) & ~misalign.
  - misalign = (wbsel = MEM) & ((lw & off != 0) | (lh/lhu & off[0] = 1)).
  - rd = 0 never asserts rf_wr; rf_a3 still reflects m_rd.
- align_err: set on the capture of a valid misaligned load and held until reset. The faulting write is suppressed; later instructions proceed normally.
- retire_cnt: increments by 1 on each normal capture with m_valid = 1, including rd = 0 writes, non-writing instructions and misaligned loads. Wraps from 0xFFFFFFFF to 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset mid-write: rf_wr = 1 with rf_a3 = 5, then rst_n low between edges -> rf_wr, rf_a3, rf_wd and retire_cnt drop to 0 immediately.
- Load formatting, m_rdata = 0x80FF7F01:
  - lb off 3 -> 0xFFFFFF80.
  - lbu off 1 -> 0x0000007F.
  - lh off 2 -> 0xFFFF80FF.
  - lhu off 0 -> 0x00007F01.
  - lw off 0 -> 0x80FF7F01.
  - Each case yields rf_wr = 1 for rd = 8.
- Link and x0: wbsel = PC+8 with m_pc = 0x00003000, rd = 31 -> rf_wd = 0x00003008, rf_wr = 1. Same with rd = 0 -> rf_wr = 0, retire_cnt +1.
- Misaligned load: lh off 1 (valid, rd = 9) -> rf_wr = 0, align_err = 1. A following lw to rd = 10 writes normally; align_err stays 1.
- Stall/flush:
  - Capture ALU 0x1234 to rd = 4, then stall 3 cycles -> outputs hold and retire_cnt holds.
  - stall and flush together -> bubble: rf_wr = 0, retire_cnt unchanged.
- Counter wrap: force 0xFFFFFFFE retirements (or preload in sim) and retire 2 valid instructions -> retire_cnt = 0x00000000.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback formatter.
// Captures the MEM-stage result, extracts and extends load bytes/halfwords,
// picks the writeback source and drives the register-file write port, which
// doubles as the forwarding copy of the pending write.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          m_valid,
    input  logic          m_regwr,
    input  logic [AW-1:0] m_rd,
    input  logic [1:0]    m_wbsel,
    input  logic [2:0]    m_ldtype,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_rdata,
    input  logic [DW-1:0] m_pc,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd,
    output logic          rf_wr,
    output logic          fwd_vld,
    output logic          align_err,
    output logic [31:0]   retire_cnt
);

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC8 = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    // Extend an 8-bit value to the datapath width, signed or unsigned.
    function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(DW-8){sgn & b[7]}}, b};
    endfunction

    // Extend a 16-bit value to the datapath width, signed or unsigned.
    function automatic logic [DW-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(DW-16){sgn & h[15]}}, h};
    endfunction

    logic [AW-1:0] rf_a3_q,      rf_a3_d;
    logic [DW-1:0] rf_wd_q,      rf_wd_d;
    logic          rf_wr_q,      rf_wr_d;
    logic          align_err_q;
    logic [31:0]   retire_cnt_q;

    logic [1:0]    off;
    logic          is_b, is_h, is_w, sgn;
    logic          misalign;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;

    // Decode the load format, extract the addressed byte/halfword and pick the writeback value.
    always_comb begin
        off      = m_alu[1:0];
        is_b     = (m_ldtype == LD_LB) || (m_ldtype == LD_LBU);
        is_h     = (m_ldtype == LD_LH) || (m_ldtype == LD_LHU);
        is_w     = ~(is_b | is_h);
        sgn      = (m_ldtype == LD_LB) || (m_ldtype == LD_LH);

        case (off)
            2'd0:    ld_byte = m_rdata[7:0];
            2'd1:    ld_byte = m_rdata[15:8];
            2'd2:    ld_byte = m_rdata[23:16];
            default: ld_byte = m_rdata[31:24];
        endcase
        ld_half = off[1] ? m_rdata[31:16] : m_rdata[15:0];

        if (is_b)      ld_data = ext8(ld_byte, sgn);
        else if (is_h) ld_data = ext16(ld_half, sgn);
        else           ld_data = m_rdata;

        misalign = (m_wbsel == WB_MEM) & ((is_w & (off != 2'd0)) | (is_h & off[0]));

        case (m_wbsel)
            WB_MEM:  rf_wd_d = ld_data;
            WB_PC8:  rf_wd_d = m_pc + DW'(8);
            WB_ALU:  rf_wd_d = m_alu;
            default: rf_wd_d = m_alu;
        endcase

        rf_a3_d = m_rd;
        rf_wr_d = m_valid & m_regwr & (m_rd != '0) & ~misalign;
    end

    // WB register: reset clears everything, flush inserts a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_a3_q      <= '0;
            rf_wd_q      <= '0;
            rf_wr_q      <= 1'b0;
            align_err_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else if (flush) begin
            rf_a3_q <= '0;
            rf_wd_q <= '0;
            rf_wr_q <= 1'b0;
        end else if (!stall) begin
            rf_a3_q      <= rf_a3_d;
            rf_wd_q      <= rf_wd_d;
            rf_wr_q      <= rf_wr_d;
            align_err_q  <= align_err_q | (m_valid & misalign);
            retire_cnt_q <= retire_cnt_q + {31'd0, m_valid};
        end
    end

    assign rf_a3      = rf_a3_q;
    assign rf_wd      = rf_wd_q;
    assign rf_wr      = rf_wr_q;
    assign fwd_vld    = rf_wr_q;
    assign align_err  = align_err_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        m_valid, m_regwr;
    logic [4:0]  m_rd;
    logic [1:0]  m_wbsel;
    logic [2:0]  m_ldtype;
    logic [31:0] m_alu, m_rdata, m_pc;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        rf_wr, fwd_vld, align_err;
    logic [31:0] retire_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // model state
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_wr;
    logic        e_err;
    logic [31:0] e_cnt;

    mem_wb_stage #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_regwr(m_regwr), .m_rd(m_rd), .m_wbsel(m_wbsel),
        .m_ldtype(m_ldtype), .m_alu(m_alu), .m_rdata(m_rdata), .m_pc(m_pc),
        .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wr(rf_wr), .fwd_vld(fwd_vld),
        .align_err(align_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural writeback value.
    function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [2:0] ldt,
                                             input logic [31:0] alu, input logic [31:0] rd,
                                             input logic [31:0] pc);
        int unsigned off, b, h;
        off = alu % 4;
        if (sel == 2'b10) return pc + 32'd8;
        if (sel != 2'b01) return alu;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (ldt)
            3'd1:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic model_mis(input logic [1:0] sel, input logic [2:0] ldt,
                                       input logic [31:0] alu);
        int unsigned off;
        logic half, word;
        off  = alu % 4;
        half = (ldt == 3'd3) || (ldt == 3'd4);
        word = !(ldt >= 3'd1 && ldt <= 3'd4);
        return (sel == 2'b01) && ((word && off != 0) || (half && (off % 2) == 1));
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".a3"},  {27'd0, rf_a3}, {27'd0, e_a3});
        chk({tag, ".wd"},  rf_wd, e_wd);
        chk({tag, ".wr"},  {31'd0, rf_wr}, {31'd0, e_wr});
        chk({tag, ".fwd"}, {31'd0, fwd_vld}, {31'd0, e_wr});
        chk({tag, ".err"}, {31'd0, align_err}, {31'd0, e_err});
        chk({tag, ".cnt"}, retire_cnt, e_cnt);
    endtask

    // Advance one clock, update the model from the applied inputs, then compare.
    task automatic step(input string tag);
        logic mis;
        @(posedge clk);
        mis = model_mis(m_wbsel, m_ldtype, m_alu);
        if (flush) begin
            e_a3 = 0; e_wd = 0; e_wr = 0;
        end else if (!stall) begin
            e_a3  = m_rd;
            e_wd  = model_wd(m_wbsel, m_ldtype, m_alu, m_rdata, m_pc);
            e_wr  = m_valid && m_regwr && (m_rd != 0) && !mis;
            e_err = e_err || (m_valid && mis);
            if (m_valid) e_cnt = e_cnt + 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] ldt,
                         input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc);
        m_valid = v; m_regwr = w; m_rd = rd; m_wbsel = sel; m_ldtype = ldt;
        m_alu = alu; m_rdata = rdat; m_pc = pc; stall = 0; flush = 0;
    endtask

    task automatic model_reset();
        e_a3 = 0; e_wd = 0; e_wr = 0; e_err = 0; e_cnt = 0;
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #22;
        check_all("reset");
        @(negedge clk); rst_n = 1;

        // reset mid-write
        drive(1, 1, 5'd5, 2'b00, 3'd0, 32'hCAFE0001, 0, 0);
        step("pre_rst");
        chk("pre_rst_wr", {31'd0, rf_wr}, 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("mid_rst");
        chk("mid_rst_a3", {27'd0, rf_a3}, 32'd0);
        @(negedge clk); rst_n = 1;

        // load formatting
        drive(1, 1, 5'd8, 2'b01, 3'd1, 32'h3, 32'h80FF7F01, 0);
        step("lb3");  chk("lb3_wd", rf_wd, 32'hFFFFFF80); chk("lb3_wr", {31'd0, rf_wr}, 32'd1);
        m_ldtype = 3'd2; m_alu = 32'h1;
        step("lbu1"); chk("lbu1_wd", rf_wd, 32'h0000007F); chk("lbu1_wr", {31'd0, rf_wr}, 32'd1);
        m_ldtype = 3'd3; m_alu = 32'h2;
        step("lh2");  chk("lh2_wd", rf_wd, 32'hFFFF80FF); chk("lh2_wr", {31'd0, rf_wr}, 32'd1);
        m_ldtype = 3'd4; m_alu = 32'h0;
        step("lhu0"); chk("lhu0_wd", rf_wd, 32'h00007F01); chk("lhu0_wr", {31'd0, rf_wr}, 32'd1);
        m_ldtype = 3'd0; m_alu = 32'h0;
        step("lw0");  chk("lw0_wd", rf_wd, 32'h80FF7F01); chk("lw0_wr", {31'd0, rf_wr}, 32'd1);

        // link and x0
        drive(1, 1, 5'd31, 2'b10, 3'd0, 0, 0, 32'h00003000);
        step("link"); chk("link_wd", rf_wd, 32'h00003008); chk("link_wr", {31'd0, rf_wr}, 32'd1);
        m_rd = 5'd0;
        step("link_x0"); chk("x0_wr", {31'd0, rf_wr}, 32'd0); chk("x0_cnt", retire_cnt, 32'd7);
        m_pc = 32'hFFFFFFFC; m_rd = 5'd1;
        step("pc_wrap"); chk("pc_wrap_wd", rf_wd, 32'h00000004);

        // misaligned load, then a normal one
        drive(1, 1, 5'd9, 2'b01, 3'd3, 32'h1001, 32'h11223344, 0);
        step("mis"); chk("mis_wr", {31'd0, rf_wr}, 32'd0); chk("mis_err", {31'd0, align_err}, 32'd1);
        drive(1, 1, 5'd10, 2'b01, 3'd0, 32'h2000, 32'h55667788, 0);
        step("after_mis"); chk("am_wr", {31'd0, rf_wr}, 32'd1); chk("am_err", {31'd0, align_err}, 32'd1);

        // stall hold, then stall+flush
        drive(1, 1, 5'd4, 2'b00, 3'd0, 32'h1234, 0, 0);
        step("alu");
        stall = 1; m_alu = 32'hDEAD; m_rd = 5'd7;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_wd", rf_wd, 32'h1234); chk("stall_a3", {27'd0, rf_a3}, 32'd4);
        flush = 1;
        step("stall_flush"); chk("sf_wr", {31'd0, rf_wr}, 32'd0); chk("sf_cnt", retire_cnt, 32'd11);

        // counter wrap
        drive(1, 1, 5'd3, 2'b00, 3'd0, 32'h1, 0, 0);
        force dut.retire_cnt_q = 32'hFFFFFFFE;
        #1 release dut.retire_cnt_q;
        e_cnt = 32'hFFFFFFFE;
        step("wrap1");
        step("wrap2"); chk("wrap_cnt", retire_cnt, 32'h00000000);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            m_valid  = ($urandom_range(0, 9) != 0);
            m_regwr  = ($urandom_range(0, 5) != 0);
            m_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            m_wbsel  = 2'($urandom);
            m_ldtype = 3'($urandom);
            m_alu    = $urandom;
            m_rdata  = $urandom;
            m_pc     = $urandom;
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
